nes_cpu_core: RTL and testbench
===============================

Name: nes_cpu_core

Overview:
- Reduced 6502-compatible CPU core for the NES datapath. Read-only bus: fetches opcodes and operands, executes a subset of the instruction set, and exposes architectural registers on debug ports.
- Sits between the system memory map (combinational read data returned on Data_bus) and the bench or debug logic.
- No write cycles, stack, or interrupts.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset. No reset-vector fetch.

Ports:
- clk_ph1  in  1  single system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- Data_bus  in  8  read data for the current Addr_bus, sampled on the rising clk_ph1 edge.
- Addr_bus  out  16  read address; combinational from state.
- IR_dbg  out  8  instruction register.
- AC_dbg  out  8  accumulator A.
- X_dbg  out  8  index X.
- Y_dbg  out  8  index Y.
- P_dbg  out  8  status {N,V,1,B,D,I,Z,C}; bit5 always reads 1.
- PC_dbg  out  16  program counter.
- cycle_dbg  out  3  current instruction cycle T (0 = opcode fetch).

Behaviour:
Reset (async, active-high):
- PC=RESET_PC; A=X=Y=0; IR=0; P=8'h20; T=0.
- Addr_bus=PC while in reset.

Sequencing:
- T0: Addr_bus=PC; edge latches IR, PC+=1.
- Each subsequent cycle drives one address and latches one byte.
- Register/flag writeback occurs on the edge ending the instruction's final cycle; the next cycle is T0.

Cycle counts:
- Immediate (LDA/LDX/LDY A9/A2/A0, ADC 69, SBC E9, CMP C9, CPX E0, CPY C0): 2 cycles. T1 reads PC, PC+=1.
- Zero page (ADC 65, SBC E5, CMP C5, CPX E4, CPY C4): 3 cycles. T1 fetches ZP address; T2 reads {8'h00, zp}.
- Absolute (ADC 6D, SBC ED, CMP CD, CPX EC, CPY CC): 4 cycles. T1 fetches lo, T2 fetches hi, T3 reads operand.
- Implied (SEC 38, CLC 18, INX E8, INY C8, DEX CA, DEY 88, TAX AA, TXA 8A, TAY A8, TYA 98): 2 cycles. T1 is a dummy read of PC with no increment.
- JMP abs 4C: 3 cycles. PC={hi,lo}.
- JMP ind 6C: 5 cycles. Pointer fetch in T1/T2, then target lo/hi. Pointer high byte is not incremented on page wrap (6502 bug): ($10FF) reads hi from $1000.
- Branches (BPL 10, BMI 30, BVC 50, BVS 70, BCC 90, BCS B0, BNE D0, BEQ F0):
  - Offset fetched in T1, PC+=1.
  - Not taken: 2 cycles.
  - Taken, same page: 3 cycles.
  - Taken, page crossed: 4 cycles.
  - Target = PC(after offset) + sign-extended offset, 16-bit wrap.
- Any other opcode, including 00 and FF: 2-cycle, 1-byte NOP. T1 is a dummy read of PC; no state change.

Arithmetic/flags:
- Loads and transfers: set N,Z from the result. Inc/dec wrap mod 256 and set N,Z.
- ADC: {C,A}=A+M+C, binary only; D is ignored. V=(A7==M7)&&(R7!=A7). Sets N,Z.
- SBC: same as ADC with M replaced by ~M.
- CMP/CPX/CPY: R=reg−M, register unchanged. C=(reg>=M), Z=(reg==M), N=R7.
- SEC/CLC: set/clear C only.

Other:
- rst asserted mid-instruction aborts it immediately; partially fetched operands are discarded.
- cycle_dbg equals T at every cycle.

Test Plan:
1. Reset release with memory 0:A9 1:0F → cycle0 Addr=0000; cycle1 Addr=0001; then AC=0F, P=20 (N=0,Z=0), PC=0002.
2. Program LDA #$0F; JMP $0101; at 0101: BPL $FB; 00FE: ADC #$05; 0100: 00 → JMP takes 3 cycles with PC=0101. BPL is taken with a page cross: 4 cycles, PC=00FE. ADC gives AC=14, C=0. Opcode 00 executes as a NOP.
3. Continue loop (2) → AC steps 14,19,…,7D. Then 7D+05=82 with N=1, V=1. BPL then falls through in 2 cycles, PC=0103.
4. SEC; LDA #$50; SBC #$F0 → AC=60, C=0, V=0, N=0. Then CMP #$60 → Z=1, C=1, AC unchanged.
5. LDX #$FF; INX; DEY (Y=0); TYA → X=00 Z=1; Y=FF N=1; AC=FF N=1.
6. JMP ($10FF) with 10FF=34, 1000=12, 1100=56 → PC=1234. Asserting rst during T2 → PC=0000, all regs cleared, cycle_dbg=0.

Source files
------------

// File: rtl/nes_cpu_core.sv
// Reduced 6502-compatible core: read-only bus, multi-cycle fetch/execute,
// architectural registers exposed on debug ports.
module nes_cpu_core #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk_ph1,
  input  logic        rst,
  input  logic [7:0]  Data_bus,
  output logic [15:0] Addr_bus,
  output logic [7:0]  IR_dbg,
  output logic [7:0]  AC_dbg,
  output logic [7:0]  X_dbg,
  output logic [7:0]  Y_dbg,
  output logic [7:0]  P_dbg,
  output logic [15:0] PC_dbg,
  output logic [2:0]  cycle_dbg
);

  localparam logic [2:0] T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3, T4 = 3'd4;

  localparam logic [2:0] M_NOP = 3'd0, M_IMM = 3'd1, M_ZP  = 3'd2, M_ABS = 3'd3,
                         M_IMP = 3'd4, M_JMP = 3'd5, M_JIND = 3'd6, M_BR = 3'd7;

  logic [15:0] pc_q, pc_d;
  logic [7:0]  ir_q, ir_d, a_q, a_d, x_q, x_d, y_q, y_d, p_q, p_d;
  logic [7:0]  lo_q, lo_d, hi_q, hi_d, tg_q, tg_d;
  logic [2:0]  t_q, t_d;

  logic [2:0]  mode;
  logic        flag, taken, br_cross, exec;
  logic [15:0] br_tgt, addr;

  always_comb begin
    mode = M_NOP;
    case (ir_q)
      8'hA9, 8'hA2, 8'hA0, 8'h69, 8'hE9, 8'hC9, 8'hE0, 8'hC0: mode = M_IMM;
      8'h65, 8'hE5, 8'hC5, 8'hE4, 8'hC4:                      mode = M_ZP;
      8'h6D, 8'hED, 8'hCD, 8'hEC, 8'hCC:                      mode = M_ABS;
      8'h38, 8'h18, 8'hE8, 8'hC8, 8'hCA, 8'h88,
      8'hAA, 8'h8A, 8'hA8, 8'h98:                             mode = M_IMP;
      8'h4C:                                                  mode = M_JMP;
      8'h6C:                                                  mode = M_JIND;
      default: if (ir_q[4:0] == 5'b10000)                     mode = M_BR;
    endcase
  end

  // Branch opcode bits [7:6] pick N/V/C/Z, bit 5 is the value that means taken.
  always_comb begin
    case (ir_q[7:6])
      2'b00:   flag = p_q[7];
      2'b01:   flag = p_q[6];
      2'b10:   flag = p_q[0];
      default: flag = p_q[1];
    endcase
  end

  assign taken    = (flag == ir_q[5]);
  assign br_tgt   = pc_q + {{8{lo_q[7]}}, lo_q};
  assign br_cross = (br_tgt[15:8] != pc_q[15:8]);

  // Address path kept apart from Data_bus-dependent logic so the bus never loops.
  always_comb begin
    addr = pc_q;
    case (t_q)
      T2:      if (mode == M_ZP) addr = {8'h00, lo_q};
      T3:      if (mode != M_BR) addr = {hi_q, lo_q};
      T4:      addr = {hi_q, lo_q + 8'd1};
      default: addr = pc_q;
    endcase
  end

  // Execute results, applied only on the final cycle of a data instruction.
  logic [7:0] a_x, x_x, y_x, p_x, m_op, cmp_reg, res;
  logic [8:0] sum, diff;
  logic       setnz;

  always_comb begin
    a_x     = a_q;
    x_x     = x_q;
    y_x     = y_q;
    p_x     = p_q;
    setnz   = 1'b1;
    m_op    = (ir_q[7:5] == 3'b111) ? ~Data_bus : Data_bus;
    sum     = {1'b0, a_q} + {1'b0, m_op} + {8'h00, p_q[0]};
    cmp_reg = ir_q[0] ? a_q : (ir_q[5] ? x_q : y_q);
    diff    = {1'b0, cmp_reg} - {1'b0, Data_bus};
    res     = 8'h00;
    case (ir_q)
      8'hA9: begin res = Data_bus; a_x = res; end
      8'hA2: begin res = Data_bus; x_x = res; end
      8'hA0: begin res = Data_bus; y_x = res; end
      8'h69, 8'h65, 8'h6D, 8'hE9, 8'hE5, 8'hED: begin
        res    = sum[7:0];
        a_x    = res;
        p_x[0] = sum[8];
        p_x[6] = (a_q[7] == m_op[7]) && (res[7] != a_q[7]);
      end
      8'hC9, 8'hC5, 8'hCD, 8'hE0, 8'hE4, 8'hEC, 8'hC0, 8'hC4, 8'hCC: begin
        res    = diff[7:0];
        p_x[0] = ~diff[8];
      end
      8'hE8: begin res = x_q + 8'd1; x_x = res; end
      8'hC8: begin res = y_q + 8'd1; y_x = res; end
      8'hCA: begin res = x_q - 8'd1; x_x = res; end
      8'h88: begin res = y_q - 8'd1; y_x = res; end
      8'hAA: begin res = a_q; x_x = res; end
      8'h8A: begin res = x_q; a_x = res; end
      8'hA8: begin res = a_q; y_x = res; end
      8'h98: begin res = y_q; a_x = res; end
      8'h38: begin p_x[0] = 1'b1; setnz = 1'b0; end
      8'h18: begin p_x[0] = 1'b0; setnz = 1'b0; end
      default: setnz = 1'b0;
    endcase
    if (setnz) begin
      p_x[7] = res[7];
      p_x[1] = (res == 8'h00);
    end
    p_x[5] = 1'b1;
  end

  always_comb begin
    pc_d = pc_q;
    ir_d = ir_q;
    a_d  = a_q;
    x_d  = x_q;
    y_d  = y_q;
    p_d  = p_q;
    lo_d = lo_q;
    hi_d = hi_q;
    tg_d = tg_q;
    t_d  = T0;
    exec = 1'b0;
    case (t_q)
      T0: begin
        ir_d = Data_bus;
        pc_d = pc_q + 16'd1;
        t_d  = T1;
      end
      T1: begin
        case (mode)
          M_IMM: begin pc_d = pc_q + 16'd1; exec = 1'b1; end
          M_IMP: exec = 1'b1;
          M_NOP: exec = 1'b0;
          M_BR: begin
            lo_d = Data_bus;
            pc_d = pc_q + 16'd1;
            t_d  = taken ? T2 : T0;
          end
          default: begin
            lo_d = Data_bus;
            pc_d = pc_q + 16'd1;
            t_d  = T2;
          end
        endcase
      end
      T2: begin
        case (mode)
          M_ZP:  exec = 1'b1;
          M_JMP: pc_d = {Data_bus, lo_q};
          M_BR: begin
            if (br_cross) t_d = T3;
            else          pc_d = br_tgt;
          end
          default: begin
            hi_d = Data_bus;
            pc_d = pc_q + 16'd1;
            t_d  = T3;
          end
        endcase
      end
      T3: begin
        case (mode)
          M_ABS:  exec = 1'b1;
          M_JIND: begin tg_d = Data_bus; t_d = T4; end
          default: pc_d = br_tgt;
        endcase
      end
      T4: pc_d = {Data_bus, tg_q};
      default: t_d = T0;
    endcase
    if (exec) begin
      a_d = a_x;
      x_d = x_x;
      y_d = y_x;
      p_d = p_x;
    end
  end

  always_ff @(posedge clk_ph1 or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
      ir_q <= 8'h00;
      a_q  <= 8'h00;
      x_q  <= 8'h00;
      y_q  <= 8'h00;
      p_q  <= 8'h20;
      lo_q <= 8'h00;
      hi_q <= 8'h00;
      tg_q <= 8'h00;
      t_q  <= T0;
    end else begin
      pc_q <= pc_d;
      ir_q <= ir_d;
      a_q  <= a_d;
      x_q  <= x_d;
      y_q  <= y_d;
      p_q  <= p_d;
      lo_q <= lo_d;
      hi_q <= hi_d;
      tg_q <= tg_d;
      t_q  <= t_d;
    end
  end

  assign Addr_bus  = addr;
  assign IR_dbg    = ir_q;
  assign AC_dbg    = a_q;
  assign X_dbg     = x_q;
  assign Y_dbg     = y_q;
  assign P_dbg     = p_q;
  assign PC_dbg    = pc_q;
  assign cycle_dbg = t_q;

endmodule

// File: tb/tb_nes_cpu_core.sv
// Bench for nes_cpu_core: instruction-level reference model over a 64K memory,
// directed programs plus randomized instruction streams.
module tb_nes_cpu_core;

  logic        clk, rst;
  logic [7:0]  Data_bus;
  logic [15:0] Addr_bus;
  logic [7:0]  IR_dbg, AC_dbg, X_dbg, Y_dbg, P_dbg;
  logic [15:0] PC_dbg;
  logic [2:0]  cycle_dbg;

  logic [7:0]  mem [0:65535];

  int checks, errors;

  // Reference model state
  int m_pc, m_a, m_x, m_y, m_ir;
  bit m_n, m_v, m_z, m_c;

  int vops [38] = '{'hA9, 'hA2, 'hA0, 'h69, 'hE9, 'hC9, 'hE0, 'hC0,
                    'h65, 'hE5, 'hC5, 'hE4, 'hC4,
                    'h6D, 'hED, 'hCD, 'hEC, 'hCC,
                    'h38, 'h18, 'hE8, 'hC8, 'hCA, 'h88, 'hAA, 'h8A, 'hA8, 'h98,
                    'h4C, 'h6C,
                    'h10, 'h30, 'h50, 'h70, 'h90, 'hB0, 'hD0, 'hF0};

  nes_cpu_core #(.RESET_PC(16'h0000)) dut (
    .clk_ph1(clk), .rst(rst), .Data_bus(Data_bus), .Addr_bus(Addr_bus),
    .IR_dbg(IR_dbg), .AC_dbg(AC_dbg), .X_dbg(X_dbg), .Y_dbg(Y_dbg),
    .P_dbg(P_dbg), .PC_dbg(PC_dbg), .cycle_dbg(cycle_dbg)
  );

  assign Data_bus = mem[Addr_bus];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [55:0] dut_vec();
    return {PC_dbg, AC_dbg, X_dbg, Y_dbg, P_dbg, IR_dbg};
  endfunction

  function automatic logic [55:0] mdl_vec();
    logic [7:0] p;
    logic [15:0] pc;
    logic [7:0] a, x, y, ir;
    p  = {m_n, m_v, 1'b1, 3'b000, m_z, m_c};
    pc = 16'(m_pc);
    a  = 8'(m_a);
    x  = 8'(m_x);
    y  = 8'(m_y);
    ir = 8'(m_ir);
    return {pc, a, x, y, p, ir};
  endfunction

  task automatic set_nz(input int r);
    m_n = (r & 128) != 0;
    m_z = (r & 255) == 0;
  endtask

  task automatic model_alu(input int op, input int v);
    int s, r;
    case (op)
      'hA9: begin m_a = v; set_nz(v); end
      'hA2: begin m_x = v; set_nz(v); end
      'hA0: begin m_y = v; set_nz(v); end
      'h69, 'h65, 'h6D, 'hE9, 'hE5, 'hED: begin
        if ((op & 'hE0) == 'hE0) v = 255 - v;
        s   = m_a + v + (m_c ? 1 : 0);
        r   = s & 255;
        m_v = ((m_a ^ r) & (v ^ r) & 128) != 0;
        m_c = s > 255;
        m_a = r;
        set_nz(r);
      end
      default: begin
        if ((op & 1) == 1)          r = m_a;
        else if ((op & 'hE0) == 'hE0) r = m_x;
        else                        r = m_y;
        m_c = r >= v;
        m_z = r == v;
        m_n = ((r - v) & 128) != 0;
      end
    endcase
  endtask

  // Executes one whole instruction at m_pc; returns its cycle count.
  task automatic model_exec(output int cyc);
    int op, lo, hi, ptr, off, tgt;
    bit tk;
    op   = mem[m_pc];
    m_ir = op;
    m_pc = (m_pc + 1) & 'hFFFF;
    cyc  = 2;
    case (op)
      'hA9, 'hA2, 'hA0, 'h69, 'hE9, 'hC9, 'hE0, 'hC0: begin
        lo = mem[m_pc]; m_pc = (m_pc + 1) & 'hFFFF;
        model_alu(op, lo);
      end
      'h65, 'hE5, 'hC5, 'hE4, 'hC4: begin
        lo = mem[m_pc]; m_pc = (m_pc + 1) & 'hFFFF;
        model_alu(op, int'(mem[lo]));
        cyc = 3;
      end
      'h6D, 'hED, 'hCD, 'hEC, 'hCC: begin
        lo = mem[m_pc]; hi = mem[(m_pc + 1) & 'hFFFF];
        m_pc = (m_pc + 2) & 'hFFFF;
        model_alu(op, int'(mem[hi * 256 + lo]));
        cyc = 4;
      end
      'h38: m_c = 1;
      'h18: m_c = 0;
      'hE8: begin m_x = (m_x + 1) & 255; set_nz(m_x); end
      'hC8: begin m_y = (m_y + 1) & 255; set_nz(m_y); end
      'hCA: begin m_x = (m_x + 255) & 255; set_nz(m_x); end
      'h88: begin m_y = (m_y + 255) & 255; set_nz(m_y); end
      'hAA: begin m_x = m_a; set_nz(m_x); end
      'h8A: begin m_a = m_x; set_nz(m_a); end
      'hA8: begin m_y = m_a; set_nz(m_y); end
      'h98: begin m_a = m_y; set_nz(m_a); end
      'h4C: begin
        lo = mem[m_pc]; hi = mem[(m_pc + 1) & 'hFFFF];
        m_pc = hi * 256 + lo;
        cyc = 3;
      end
      'h6C: begin
        lo = mem[m_pc]; hi = mem[(m_pc + 1) & 'hFFFF];
        ptr = hi * 256 + lo;
        lo = mem[ptr];
        hi = mem[(ptr & 'hFF00) | ((ptr + 1) & 'hFF)];
        m_pc = hi * 256 + lo;
        cyc = 5;
      end
      'h10, 'h30, 'h50, 'h70, 'h90, 'hB0, 'hD0, 'hF0: begin
        off = mem[m_pc]; m_pc = (m_pc + 1) & 'hFFFF;
        case (op)
          'h10: tk = !m_n;  'h30: tk = m_n;
          'h50: tk = !m_v;  'h70: tk = m_v;
          'h90: tk = !m_c;  'hB0: tk = m_c;
          'hD0: tk = !m_z;  default: tk = m_z;
        endcase
        if (tk) begin
          tgt  = (m_pc + (off >= 128 ? off - 256 : off)) & 'hFFFF;
          cyc  = ((tgt >> 8) == (m_pc >> 8)) ? 3 : 4;
          m_pc = tgt;
        end
      end
      default: ;
    endcase
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst  = 1'b0;
    m_pc = 0; m_a = 0; m_x = 0; m_y = 0; m_ir = 0;
    m_n = 0; m_v = 0; m_z = 0; m_c = 0;
  endtask

  // Clocks the DUT through one instruction; n = cycles seen, seq_ok = cycle_dbg counted 1,2,...
  task automatic run_instr(output int n, output bit seq_ok);
    n = 0;
    seq_ok = 1'b1;
    do begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (cycle_dbg != 3'd0 && cycle_dbg != 3'(n)) seq_ok = 1'b0;
    end while (cycle_dbg != 3'd0 && n < 8);
  endtask

  task automatic test_reset();
    clear_mem();
    mem[0] = 8'hA9; mem[1] = 8'h0F;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (Addr_bus !== 16'h0000 || cycle_dbg !== 3'd0) begin
      errors++; $display("FAIL reset_addr: got %h/%0d want 0000/0", Addr_bus, cycle_dbg);
    end
    checks++;
    if (dut_vec() !== {16'h0000, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00}) begin
      errors++; $display("FAIL reset_regs: got %h want 0000000000 2000", dut_vec());
    end
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (Addr_bus !== 16'h0000) begin
      errors++; $display("FAIL t0_addr: got %h want 0000", Addr_bus);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (Addr_bus !== 16'h0001 || cycle_dbg !== 3'd1) begin
      errors++; $display("FAIL t1_addr: got %h/%0d want 0001/1", Addr_bus, cycle_dbg);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (AC_dbg !== 8'h0F || P_dbg !== 8'h20 || PC_dbg !== 16'h0002 || cycle_dbg !== 3'd0) begin
      errors++;
      $display("FAIL lda_imm: got AC=%h P=%h PC=%h T=%0d want 0F 20 0002 0",
               AC_dbg, P_dbg, PC_dbg, cycle_dbg);
    end
  endtask

  task automatic test_branch_loop();
    int n, ec, iters, last_n;
    bit ok;
    clear_mem();
    mem['h0000] = 8'hA9; mem['h0001] = 8'h0F;
    mem['h0002] = 8'h4C; mem['h0003] = 8'h01; mem['h0004] = 8'h01;
    mem['h0101] = 8'h10; mem['h0102] = 8'hFB;
    mem['h00FE] = 8'h69; mem['h00FF] = 8'h05;
    mem['h0100] = 8'h00;
    do_reset();
    run_instr(n, ok); model_exec(ec);
    checks++;
    if (n !== 2 || !ok || dut_vec() !== mdl_vec()) begin
      errors++; $display("FAIL loop_lda: got %h n=%0d want %h n=2", dut_vec(), n, mdl_vec());
    end
    run_instr(n, ok); model_exec(ec);
    checks++;
    if (n !== 3 || !ok || PC_dbg !== 16'h0101) begin
      errors++; $display("FAIL jmp_abs: got PC=%h n=%0d want 0101 n=3", PC_dbg, n);
    end
    run_instr(n, ok); model_exec(ec);
    checks++;
    if (n !== 4 || !ok || PC_dbg !== 16'h00FE) begin
      errors++; $display("FAIL bpl_cross: got PC=%h n=%0d want 00FE n=4", PC_dbg, n);
    end
    run_instr(n, ok); model_exec(ec);
    checks++;
    if (AC_dbg !== 8'h14 || P_dbg[0] !== 1'b0 || n !== 2) begin
      errors++; $display("FAIL adc_first: got AC=%h C=%b n=%0d want 14 0 2", AC_dbg, P_dbg[0], n);
    end
    run_instr(n, ok); model_exec(ec);
    checks++;
    if (n !== 2 || PC_dbg !== 16'h0101 || dut_vec() !== mdl_vec()) begin
      errors++; $display("FAIL nop00: got %h n=%0d want %h n=2", dut_vec(), n, mdl_vec());
    end
    iters = 0;
    last_n = 0;
    while (m_pc != 'h0103 && iters < 200) begin
      run_instr(n, ok); model_exec(ec);
      last_n = n;
      iters++;
      checks++;
      if (n !== ec || !ok || dut_vec() !== mdl_vec()) begin
        errors++; $display("FAIL loop_step%0d: got %h n=%0d want %h n=%0d",
                           iters, dut_vec(), n, mdl_vec(), ec);
      end
    end
    checks++;
    if (AC_dbg !== 8'h82 || P_dbg[7] !== 1'b1 || P_dbg[6] !== 1'b1 ||
        PC_dbg !== 16'h0103 || last_n !== 2) begin
      errors++;
      $display("FAIL loop_exit: got AC=%h P=%h PC=%h n=%0d want 82 N=1 V=1 0103 2",
               AC_dbg, P_dbg, PC_dbg, last_n);
    end
  endtask

  task automatic test_sbc_cmp();
    int n, ec;
    bit ok;
    clear_mem();
    mem[0] = 8'h38; mem[1] = 8'hA9; mem[2] = 8'h50;
    mem[3] = 8'hE9; mem[4] = 8'hF0; mem[5] = 8'hC9; mem[6] = 8'h60;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      run_instr(n, ok); model_exec(ec);
      checks++;
      if (n !== ec || !ok || dut_vec() !== mdl_vec()) begin
        errors++; $display("FAIL sbc_seq%0d: got %h want %h", i, dut_vec(), mdl_vec());
      end
    end
    checks++;
    if (AC_dbg !== 8'h60 || P_dbg[0] !== 1'b0 || P_dbg[6] !== 1'b0 || P_dbg[7] !== 1'b0) begin
      errors++; $display("FAIL sbc: got AC=%h P=%h want 60 C=0 V=0 N=0", AC_dbg, P_dbg);
    end
    run_instr(n, ok); model_exec(ec);
    checks++;
    if (AC_dbg !== 8'h60 || P_dbg[1] !== 1'b1 || P_dbg[0] !== 1'b1 || n !== 2) begin
      errors++; $display("FAIL cmp: got AC=%h P=%h n=%0d want 60 Z=1 C=1 2", AC_dbg, P_dbg, n);
    end
  endtask

  task automatic test_index();
    int n, ec;
    bit ok;
    clear_mem();
    mem[0] = 8'hA2; mem[1] = 8'hFF; mem[2] = 8'hE8; mem[3] = 8'h88; mem[4] = 8'h98;
    do_reset();
    run_instr(n, ok); model_exec(ec);
    run_instr(n, ok); model_exec(ec);
    checks++;
    if (X_dbg !== 8'h00 || P_dbg[1] !== 1'b1 || n !== 2 || dut_vec() !== mdl_vec()) begin
      errors++; $display("FAIL inx_wrap: got X=%h P=%h n=%0d want 00 Z=1 2", X_dbg, P_dbg, n);
    end
    run_instr(n, ok); model_exec(ec);
    checks++;
    if (Y_dbg !== 8'hFF || P_dbg[7] !== 1'b1 || dut_vec() !== mdl_vec()) begin
      errors++; $display("FAIL dey_wrap: got Y=%h P=%h want FF N=1", Y_dbg, P_dbg);
    end
    run_instr(n, ok); model_exec(ec);
    checks++;
    if (AC_dbg !== 8'hFF || P_dbg[7] !== 1'b1 || dut_vec() !== mdl_vec()) begin
      errors++; $display("FAIL tya: got AC=%h P=%h want FF N=1", AC_dbg, P_dbg);
    end
  endtask

  task automatic test_jmp_ind_reset();
    int n, ec;
    bit ok;
    clear_mem();
    mem['h0000] = 8'h6C; mem['h0001] = 8'hFF; mem['h0002] = 8'h10;
    mem['h10FF] = 8'h34; mem['h1000] = 8'h12; mem['h1100] = 8'h56;
    mem['h1234] = 8'hA9; mem['h1235] = 8'h80;
    mem['h1236] = 8'h6C; mem['h1237] = 8'hFF; mem['h1238] = 8'h10;
    do_reset();
    run_instr(n, ok); model_exec(ec);
    checks++;
    if (n !== 5 || !ok || PC_dbg !== 16'h1234) begin
      errors++; $display("FAIL jmp_ind: got PC=%h n=%0d want 1234 5", PC_dbg, n);
    end
    run_instr(n, ok); model_exec(ec);
    checks++;
    if (AC_dbg !== 8'h80 || P_dbg !== 8'hA0) begin
      errors++; $display("FAIL lda_neg: got AC=%h P=%h want 80 A0", AC_dbg, P_dbg);
    end
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    checks++;
    if (cycle_dbg !== 3'd2) begin
      errors++; $display("FAIL mid_instr_t: got %0d want 2", cycle_dbg);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (dut_vec() !== {16'h0000, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00} ||
        cycle_dbg !== 3'd0 || Addr_bus !== 16'h0000) begin
      errors++; $display("FAIL async_abort: got %h T=%0d A=%h want 0000000000 2000 T=0 A=0000",
                         dut_vec(), cycle_dbg, Addr_bus);
    end
    @(negedge clk);
    rst = 1'b0;
    m_pc = 0; m_a = 0; m_x = 0; m_y = 0; m_ir = 0;
    m_n = 0; m_v = 0; m_z = 0; m_c = 0;
    run_instr(n, ok); model_exec(ec);
    checks++;
    if (n !== 5 || PC_dbg !== 16'h1234 || dut_vec() !== mdl_vec()) begin
      errors++; $display("FAIL restart: got %h n=%0d want %h 5", dut_vec(), n, mdl_vec());
    end
  endtask

  task automatic test_random();
    int n, ec;
    bit ok;
    for (int round = 0; round < 3; round++) begin
      for (int i = 0; i < 65536; i++)
        mem[i] = ($urandom_range(3) == 0) ? 8'($urandom) : 8'(vops[$urandom_range(37)]);
      do_reset();
      for (int k = 0; k < 300; k++) begin
        checks++;
        if (Addr_bus !== 16'(m_pc) || cycle_dbg !== 3'd0) begin
          errors++; $display("FAIL rnd_fetch r%0d i%0d: got %h/%0d want %h/0",
                             round, k, Addr_bus, cycle_dbg, 16'(m_pc));
        end
        run_instr(n, ok); model_exec(ec);
        checks++;
        if (n !== ec || !ok || dut_vec() !== mdl_vec()) begin
          errors++; $display("FAIL rnd_exec r%0d i%0d op=%h: got %h n=%0d want %h n=%0d",
                             round, k, 8'(m_ir), dut_vec(), n, mdl_vec(), ec);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    test_reset();
    test_branch_loop();
    test_sbc_cmp();
    test_index();
    test_jmp_ind_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
